// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 pixel path.
package ws2812_pkg;

    localparam int unsigned GRB_BITS = 24;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } src_state_t;

    // (c * (bright + 1)) >> 8: bright=255 is identity, bright=0 blanks the channel.
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] bright);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, bright} + 16'd1);
        return 8'(prod >> 8);
    endfunction

endpackage

// File: rtl/ws2812_pixel_source_if.sv
// Pixel word handshake between the pixel source and the bit serializer.
interface ws2812_pixel_source_if
    import ws2812_pkg::*;
();

    logic                px_valid;
    logic [GRB_BITS-1:0] px_data;
    logic                px_last;
    logic                px_ready;

    modport master (
        output px_valid,
        output px_data,
        output px_last,
        input  px_ready
    );

    modport slave (
        input  px_valid,
        input  px_data,
        input  px_last,
        output px_ready
    );

endinterface

// File: rtl/ws2812_scale.sv
// Registered per-channel brightness scaling stage with valid/last sideband.
module ws2812_scale
    import ws2812_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       valid_i,
    input  logic       last_i,
    input  grb_t       data_i,
    input  logic [7:0] bright_i,
    output logic       valid_o,
    output logic       last_o,
    output grb_t       data_o
);

    logic valid_q;
    logic last_q;
    grb_t data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q  <= valid_i;
            last_q   <= last_i & valid_i;
            data_q.g <= scale_chan(data_i.g, bright_i);
            data_q.r <= scale_chan(data_i.r, bright_i);
            data_q.b <= scale_chan(data_i.b, bright_i);
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ws2812_pixel_source.sv
// Frame buffer plus per-frame rotated, brightness-scaled pixel streamer feeding the serializer.
module ws2812_pixel_source
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = 50,
    parameter int unsigned FRAME_CYCLES = 2500000,
    parameter int unsigned ROT_STEP     = 1,
    parameter int unsigned AW           = $clog2(NUM_LEDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [GRB_BITS-1:0]   wr_data_i,
    input  logic [7:0]            bright_i,
    input  logic                  start_i,
    input  logic                  overrun_clr_i,
    ws2812_pixel_source_if.master px_if,
    output logic                  frame_busy_o,
    output logic                  overrun_o
);

    localparam int unsigned TW          = $clog2(FRAME_CYCLES);
    localparam int unsigned TimerMaxInt = FRAME_CYCLES - 1;
    localparam int unsigned LastIdxInt  = NUM_LEDS - 1;

    localparam logic [TW-1:0] TimerMax = TimerMaxInt[TW-1:0];
    localparam logic [AW:0]   NumLeds  = NUM_LEDS[AW:0];
    localparam logic [AW:0]   RotStep  = ROT_STEP[AW:0];
    localparam logic [AW-1:0] LastIdx  = LastIdxInt[AW-1:0];

    logic [TW-1:0] timer_q, timer_d;
    logic          tick;
    logic          trigger;
    logic          advance;
    logic          issue;
    logic          wr_ok;

    src_state_t    state_q;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] base_q;
    logic [AW-1:0] offset_q;
    logic [AW-1:0] offset_next;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_sum;
    logic [AW:0]   off_sum;
    logic [7:0]    bright_q;
    logic          busy_q;
    logic          overrun_q;

    logic [GRB_BITS-1:0] mem_q [2**AW];
    logic [GRB_BITS-1:0] rd_data_q;
    logic                rd_valid_q;
    logic                rd_last_q;

    logic px_valid;
    logic px_last;
    grb_t px_data;

    // Frame timer; the wrap cycle is the tick.
    assign tick    = (timer_q == TimerMax);
    assign trigger = tick | start_i;

    always_comb begin
        timer_d = tick ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // A stalled output freezes every stage, including the RAM read.
    assign advance = ~px_valid | px_if.px_ready;
    assign issue   = (state_q == STREAM) & advance;
    assign wr_ok   = wr_en_i & ({1'b0, wr_addr_i} < NumLeds);

    always_comb begin
        rd_sum      = {1'b0, idx_q} + {1'b0, base_q};
        rd_addr     = (rd_sum >= NumLeds) ? AW'(rd_sum - NumLeds) : AW'(rd_sum);
        off_sum     = {1'b0, offset_q} + RotStep;
        offset_next = (off_sum >= NumLeds) ? AW'(off_sum - NumLeds) : AW'(off_sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            offset_q  <= '0;
            bright_q  <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // A trigger while busy beats a simultaneous clear.
            if (trigger && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (trigger) begin
                        bright_q <= bright_i;
                        base_q   <= offset_q;
                        offset_q <= offset_next;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= STREAM;
                    end
                end
                STREAM: begin
                    if (advance) begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == LastIdx) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (px_valid && px_if.px_ready && px_last) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Simple dual-port frame buffer; a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (issue) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else if (advance) begin
            rd_valid_q <= issue;
            rd_last_q  <= issue & (idx_q == LastIdx);
        end
    end

    ws2812_scale u_scale (
        .clk      (clk),
        .rst      (rst),
        .en_i     (advance),
        .valid_i  (rd_valid_q),
        .last_i   (rd_last_q),
        .data_i   (grb_t'(rd_data_q)),
        .bright_i (bright_q),
        .valid_o  (px_valid),
        .last_o   (px_last),
        .data_o   (px_data)
    );

    assign px_if.px_valid = px_valid;
    assign px_if.px_data  = px_data;
    assign px_if.px_last  = px_last;
    assign frame_busy_o   = busy_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_ws2812_pixel_source.sv
// Randomized bench for ws2812_pixel_source against a frame-level scoreboard model.
module tb_ws2812_pixel_source;
    import ws2812_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned FC = 64;
    localparam int unsigned RS = 1;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic [7:0]    bright = 8'd255;
    logic          start = 1'b0;
    logic          overrun_clr = 1'b0;
    logic          frame_busy;
    logic          overrun;

    ws2812_pixel_source_if px_if ();

    ws2812_pixel_source #(
        .NUM_LEDS     (N),
        .FRAME_CYCLES (FC),
        .ROT_STEP     (RS),
        .AW           (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .bright_i      (bright),
        .start_i       (start),
        .overrun_clr_i (overrun_clr),
        .px_if         (px_if),
        .frame_busy_o  (frame_busy),
        .overrun_o     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level model: frames, offsets and pixels from plain arithmetic.
    logic [23:0] m_mem [N];
    logic [23:0] acc_px [N];
    logic [23:0] last_acc;
    logic [23:0] prev_data;
    logic        prev_last;
    logic [7:0]  m_bright;
    bit          m_busy = 0;
    bit          m_ovr = 0;
    bit          prev_stall = 0;
    int          m_offset = 0;
    int          m_base = 0;
    int          m_count = 0;
    int          m_tcnt = 0;
    int          m_frames = 0;
    int          hs_total = 0;

    function automatic logic [23:0] ref_px(input logic [23:0] p, input logic [7:0] b);
        int g, r, bl;
        g  = (int'(p[23:16]) * (int'(b) + 1)) / 256;
        r  = (int'(p[15:8]) * (int'(b) + 1)) / 256;
        bl = (int'(p[7:0]) * (int'(b) + 1)) / 256;
        return {g[7:0], r[7:0], bl[7:0]};
    endfunction

    always @(negedge clk) begin
        bit tick, trig, was_busy;
        if (rst) begin
            m_offset   = 0;
            m_busy     = 0;
            m_ovr      = 0;
            m_tcnt     = 0;
            m_count    = 0;
            prev_stall = 0;
            check("rst_valid", {31'd0, px_if.px_valid}, 32'd0);
        end
        check("frame_busy", {31'd0, frame_busy}, {31'd0, m_busy});
        check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, px_if.px_valid}, 32'd1);
                check("stall_data", {8'd0, px_if.px_data}, {8'd0, prev_data});
                check("stall_last", {31'd0, px_if.px_last}, {31'd0, prev_last});
            end
            // Effect of the coming rising edge.
            tick     = (m_tcnt == FC - 1);
            m_tcnt   = tick ? 0 : m_tcnt + 1;
            trig     = start | tick;
            was_busy = m_busy;
            if (trig && was_busy) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
            if (px_if.px_valid && px_if.px_ready) begin
                hs_total++;
                check("hs_in_frame", {31'd0, was_busy}, 32'd1);
                if (was_busy) begin
                    check("px_data", {8'd0, px_if.px_data},
                          {8'd0, ref_px(m_mem[(m_count + m_base) % N], m_bright)});
                    check("px_last", {31'd0, px_if.px_last}, {31'd0, m_count == N - 1});
                    acc_px[m_count] = px_if.px_data;
                    last_acc = px_if.px_data;
                    m_count++;
                    if (m_count == N) m_busy = 0;
                end
            end
            if (trig && !was_busy) begin
                m_base   = m_offset;
                m_offset = (m_offset + RS) % N;
                m_bright = bright;
                m_count  = 0;
                m_busy   = 1;
                m_frames++;
            end
            if (wr_en && (wr_addr < N)) m_mem[wr_addr] = wr_data;
            prev_stall = px_if.px_valid && !px_if.px_ready;
            prev_data  = px_if.px_data;
            prev_last  = px_if.px_last;
        end
    end

    // 0: ready high, 1: 1,0,0,1 pattern, 2: random, 3: ready low
    int ready_mode = 0;
    int phase = 0;

    task automatic step();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: px_if.px_ready = 1'b1;
            1: begin
                px_if.px_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
                phase++;
            end
            2: px_if.px_ready = 1'($urandom_range(0, 1));
            default: px_if.px_ready = 1'b0;
        endcase
    endtask

    task automatic write_px(input logic [AW-1:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!frame_busy && !m_busy) return;
            step();
        end
        check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Idle and far enough from the next tick for writes plus a short frame.
    task automatic safe_window();
        for (int i = 0; i < 400; i++) begin
            if (!frame_busy && !m_busy && (m_tcnt < 40)) return;
            step();
        end
        check("window_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int h0;
        bit seen;
        px_if.px_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_px_valid", {31'd0, px_if.px_valid}, 32'd0);
        check("rst_px_data", {8'd0, px_if.px_data}, 32'd0);
        check("rst_px_last", {31'd0, px_if.px_last}, 32'd0);
        check("rst_busy", {31'd0, frame_busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

        // Basic frame, latency and rotation on the next tick.
        write_px(0, 24'h000011);
        write_px(1, 24'h000022);
        write_px(2, 24'h000033);
        write_px(3, 24'h000044);
        bright = 8'd255;
        pulse_start();
        check("busy_after_start", {31'd0, frame_busy}, 32'd1);
        step();
        check("latency_1", {31'd0, px_if.px_valid}, 32'd0);
        step();
        check("latency_2", {31'd0, px_if.px_valid}, 32'd1);
        wait_idle();
        check("t1_first", {8'd0, acc_px[0]}, 32'h11);
        check("t1_final", {8'd0, acc_px[3]}, 32'h44);
        f0 = m_frames;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            seen = (m_frames != f0);
        end
        check("tick_frame_seen", {31'd0, seen}, 32'd1);
        wait_idle();
        check("rot_first", {8'd0, acc_px[0]}, 32'h22);
        check("rot_final", {8'd0, acc_px[3]}, 32'h11);

        // Brightness boundaries.
        safe_window();
        for (int a = 0; a < 4; a++) write_px(3'(a), 24'hFF8001);
        bright = 8'd127;
        pulse_start();
        wait_idle();
        check("bright_127", {8'd0, last_acc}, 32'h7F4000);
        safe_window();
        bright = 8'd0;
        pulse_start();
        wait_idle();
        check("bright_0", {8'd0, last_acc}, 32'h0);

        // Backpressure pattern 1,0,0,1.
        safe_window();
        write_px(0, 24'h000011);
        write_px(1, 24'h000022);
        write_px(2, 24'h000033);
        write_px(3, 24'h000044);
        bright = 8'd255;
        ready_mode = 1;
        phase = 0;
        h0 = hs_total;
        pulse_start();
        wait_idle();
        check("pattern_hs", hs_total - h0, 32'd4);
        ready_mode = 0;

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            ready_mode = 0;
            safe_window();
            for (int a = 0; a < 4; a++) write_px(3'(a), 24'($urandom));
            bright = 8'($urandom);
            ready_mode = 2;
            pulse_start();
            wait_idle();
        end

        // Overrun while stalled across a tick.
        ready_mode = 0;
        safe_window();
        ready_mode = 3;
        px_if.px_ready = 1'b0;
        h0 = hs_total;
        pulse_start();
        repeat (70) step();
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check("ovr_no_restart", {31'd0, frame_busy}, 32'd1);
        check("ovr_no_hs", hs_total - h0, 32'd0);
        if (m_tcnt == FC - 1) step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr_clr", {31'd0, overrun}, 32'd0);
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (m_tcnt == FC - 1) seen = 1;
            else step();
        end
        check("tick_align", {31'd0, seen}, 32'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr_clr_loses", {31'd0, overrun}, 32'd1);
        ready_mode = 0;
        wait_idle();

        // Reset mid-stream with overrun still set.
        safe_window();
        pulse_start();
        step();
        step();
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, px_if.px_valid}, 32'd0);
        check("arst_busy", {31'd0, frame_busy}, 32'd0);
        check("arst_overrun", {31'd0, overrun}, 32'd0);
        repeat (3) step();
        rst = 1'b0;

        // First frame after reset: offset 0, retained buffer, write during stream.
        bright = 8'd255;
        ready_mode = 3;
        px_if.px_ready = 1'b0;
        write_px(7, 24'h123456);
        pulse_start();
        repeat (4) step();
        write_px(2, 24'hABCDEF);
        ready_mode = 0;
        wait_idle();
        check("retain_px0", {8'd0, acc_px[0]}, {8'd0, m_mem[0]});
        check("retain_px3", {8'd0, acc_px[3]}, {8'd0, m_mem[3]});
        check("wr_during_stream", {8'd0, acc_px[2]}, 32'hABCDEF);

        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
